// File: rtl/word_select_arb.sv
// Registered N-way word selector with valid/ready handshakes.
// Picks one of NUM_SRC sources, by explicit select (mode = 0) or
// round-robin (mode = 1), into a one-entry output register.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   mode       0 = explicit select, 1 = round-robin
//   select     source index used when mode = 0
//   src_valid  per-source word valid
//   src_data   source i at bits [i*WIDTH +: WIDTH]
//   src_ready  per-source accept (one-hot or zero), combinational
//   out_valid  output register holds a word
//   out_data   registered selected word
//   out_src    index of the source that supplied out_data
//   out_ready  consumer accepts out_data
module word_select_arb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         select,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             can_accept;
  logic             xfer_in;
  logic [WIDTH-1:0] sel_data;
  int unsigned      pos;

  // A drain and a load may happen in the same cycle.
  assign can_accept = !out_valid || out_ready;
  // Nothing is accepted while reset is asserted.
  assign xfer_in    = grant_vld && can_accept && !rst;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = 0;
    if (!mode) begin
      // An out-of-range select matches no source, so it never grants.
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (SEL_W'(i) == select && src_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Scan rr_ptr, rr_ptr+1, ... with wrap; first valid source wins.
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        pos = int'(rr_ptr) + k;
        if (pos >= NUM_SRC) pos = pos - NUM_SRC;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (!grant_vld && i == pos && src_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    src_ready = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SEL_W'(i) == grant_idx) begin
        src_ready[i] = xfer_in;
        sel_data     = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= grant_idx;
        // Pointer only advances on round-robin loads so mode 0 leaves it parked.
        if (mode) begin
          rr_ptr <= (grant_idx == SEL_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_select_arb.sv
// Directed bench for word_select_arb: a 4-source instance for reset, select,
// round-robin and backpressure, plus a 3-source instance for out-of-range select.
module tb_word_select_arb;

  logic        clk = 1'b0;
  logic        rst;
  int          tests = 0;
  int          fails = 0;

  // 4-source instance
  logic        mode;
  logic [1:0]  select;
  logic [3:0]  src_valid;
  logic [127:0] src_data;
  logic [3:0]  src_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  // 3-source instance
  logic        mode3;
  logic [1:0]  select3;
  logic [2:0]  src_valid3;
  logic [95:0] src_data3;
  logic [2:0]  src_ready3;
  logic        out_valid3;
  logic [31:0] out_data3;
  logic [1:0]  out_src3;
  logic        out_ready3;

  always #5 clk = ~clk;

  word_select_arb #(.WIDTH(32), .NUM_SRC(4)) u0 (
    .clk(clk), .rst(rst), .mode(mode), .select(select),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  word_select_arb #(.WIDTH(32), .NUM_SRC(3)) u1 (
    .clk(clk), .rst(rst), .mode(mode3), .select(select3),
    .src_valid(src_valid3), .src_data(src_data3), .src_ready(src_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_src(out_src3),
    .out_ready(out_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_exp [8];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    rst        = 1'b1;
    mode       = 1'b1;
    select     = 2'd0;
    src_valid  = 4'b1111;
    src_data   = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    out_ready  = 1'b1;
    mode3      = 1'b0;
    select3    = 2'd3;
    src_valid3 = 3'b111;
    src_data3  = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    out_ready3 = 1'b1;

    // Reset for two cycles with every source valid
    tick();
    chk("rst_ready_c1", 32'(src_ready), 32'h0);
    tick();
    chk("rst_ready_c2", 32'(src_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);

    // First round-robin grant after reset goes to source 0
    rst = 1'b0;
    #1;
    chk("rr_first_ready", 32'(src_ready), 32'h1);

    // Round-robin fairness over 8 consecutive loads
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_seq_src%0d", k), 32'(out_src), 32'(rr_exp[k]));
      chk($sformatf("rr_seq_valid%0d", k), 32'(out_valid), 32'h1);
    end
    chk("rr_seq_last_data", out_data, 32'h44444444);

    // Explicit select of source 2
    mode   = 1'b0;
    select = 2'd2;
    #1;
    chk("sel2_ready", 32'(src_ready), 32'h4);
    tick();
    chk("sel2_data", out_data, 32'hDEADBEEF);
    chk("sel2_src", 32'(out_src), 32'h2);

    // Park rr_ptr at 3 by a round-robin load from source 2 (rr_ptr was 0)
    mode      = 1'b1;
    src_valid = 4'b0100;
    #1;
    chk("rr_to3_ready", 32'(src_ready), 32'h4);
    tick();
    // Skip/wrap: pointer 3, only sources 0 and 1 valid
    src_valid = 4'b0011;
    #1;
    chk("wrap_ready0", 32'(src_ready), 32'h1);
    tick();
    chk("wrap_src0", 32'(out_src), 32'h0);
    chk("wrap_ready1", 32'(src_ready), 32'h2);
    tick();
    chk("wrap_src1", 32'(out_src), 32'h1);
    chk("wrap_data1", out_data, 32'h22222222);
    src_valid = 4'b1111;
    #1;
    chk("wrap_ptr2_ready", 32'(src_ready), 32'h4);

    // Backpressure: hold for 3 cycles
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(src_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_data%0d", k), out_data, 32'h22222222);
      chk($sformatf("bp_src%0d", k), 32'(out_src), 32'h1);
      chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'h1);
      chk($sformatf("bp_ready%0d", k), 32'(src_ready), 32'h0);
    end
    // Release: drain and reload in the same cycle
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(src_ready), 32'h4);
    tick();
    chk("bp_reload_valid", 32'(out_valid), 32'h1);
    chk("bp_reload_src", 32'(out_src), 32'h2);
    chk("bp_reload_data", out_data, 32'hDEADBEEF);
    // Drain with nothing valid: valid drops, data/src hold
    src_valid = 4'b0000;
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_data", out_data, 32'hDEADBEEF);
    chk("drain_src", 32'(out_src), 32'h2);

    // 3-source instance: select = 3 is out of range, never granted
    chk("oor_ready", 32'(src_ready3), 32'h0);
    chk("oor_no_load", 32'(out_valid3), 32'h0);
    select3 = 2'd1;
    #1;
    chk("n3_sel1_ready", 32'(src_ready3), 32'h2);
    tick();
    chk("n3_sel1_valid", 32'(out_valid3), 32'h1);
    chk("n3_sel1_data", out_data3, 32'hB1B1B1B1);
    chk("n3_sel1_src", 32'(out_src3), 32'h1);

    // Mid-transfer reset drops the held word
    out_ready3 = 1'b0;
    rst        = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid3), 32'h0);
    chk("midrst_data", out_data3, 32'h0);

    // rr_ptr returns to 0 after reset: first valid from 0 upward is source 1
    rst       = 1'b0;
    mode      = 1'b1;
    src_valid = 4'b1110;
    #1;
    chk("post_rst_rr_ready", 32'(src_ready), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
